// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle datapath: FSM control, PC, register bank, ALU, flags, req/ack memory ports
module multicycle_datapath #(
  parameter int DATA_W = 16,
  parameter int NREG = 8,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              PCrst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [2:0] C_ALU_RR = 3'd0;
  localparam logic [2:0] C_ALU_RI = 3'd1;
  localparam logic [2:0] C_LOAD   = 3'd2;
  localparam logic [2:0] C_STORE  = 3'd3;
  localparam logic [2:0] C_JUMP   = 3'd4;
  localparam logic [2:0] C_CALL   = 3'd5;
  localparam logic [2:0] C_NOP    = 3'd6;
  localparam logic [2:0] C_HALT   = 3'd7;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_AND = 3'd2;
  localparam logic [2:0] F_OR  = 3'd3;
  localparam logic [2:0] F_XOR = 3'd4;
  localparam logic [2:0] F_SHL = 3'd5;
  localparam logic [2:0] F_SHR = 3'd6;

  state_t            state;
  logic [31:0]       iw;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] sd_q;
  logic [DATA_W-1:0] res_q;
  logic [3:0]        flags_q;
  logic              halted_q;
  logic              dmem_we_q;

  logic [2:0]        cls;
  logic [2:0]        fn;
  logic [3:0]        cond;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [DATA_W-1:0] imm_d;
  logic [ADDR_W-1:0] imm_a;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_bits;

  assign cls    = iw[31:29];
  assign fn     = iw[28:26];
  assign cond   = iw[28:25];
  assign rd     = iw[21 +: REG_AW];
  assign rs1    = iw[17 +: REG_AW];
  assign rs2    = iw[0 +: REG_AW];
  assign imm_d  = DATA_W'(iw[15:0]);
  assign imm_a  = ADDR_W'(iw[15:0]);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign unused_bits = ^{iw[24:16], iw[3:0]};

  function automatic logic [DATA_W-1:0] rreg(input logic [REG_AW-1:0] idx);
    return (idx == '0) ? '0 : regs[idx];
  endfunction

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fn)
      F_ADD: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      F_SUB: begin
        // carry out of A + ~B + 1, so C=1 means no borrow
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
      end
      F_AND: alu_res = a_q & b_q;
      F_OR:  alu_res = a_q | b_q;
      F_XOR: alu_res = a_q ^ b_q;
      F_SHL: begin
        alu_res = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      F_SHR: begin
        alu_res = {1'b0, a_q[DATA_W-1:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = b_q;
    endcase
  end

  logic cond_ok;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'd0: cond_ok = 1'b1;
      4'd1: cond_ok = flags_q[0];
      4'd2: cond_ok = !flags_q[0];
      4'd3: cond_ok = flags_q[1];
      4'd4: cond_ok = !flags_q[1];
      4'd5: cond_ok = flags_q[2];
      4'd6: cond_ok = flags_q[3];
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge PCrst_n) begin
    if (!PCrst_n) begin
      state     <= S_FETCH;
      pc_q      <= RESET_PC;
      iw        <= '0;
      addr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sd_q      <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      halted_q  <= 1'b0;
      dmem_we_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            iw    <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q   <= rreg(rs1);
          b_q   <= (cls == C_ALU_RR) ? rreg(rs2) : imm_d;
          sd_q  <= rreg(rd);
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_ALU_RR, C_ALU_RI: begin
              res_q   <= alu_res;
              flags_q <= {alu_v, alu_res[DATA_W-1], alu_c, alu_res == '0};
              state   <= S_WB;
            end
            C_LOAD, C_STORE: begin
              addr_q    <= ADDR_W'(a_q) + imm_a;
              dmem_we_q <= (cls == C_STORE);
              state     <= S_MEM;
            end
            C_JUMP: begin
              pc_q  <= cond_ok ? imm_a : pc_inc;
              state <= S_FETCH;
            end
            C_CALL: begin
              regs[NREG-1] <= DATA_W'(pc_inc);
              pc_q         <= imm_a;
              state        <= S_FETCH;
            end
            C_NOP: begin
              pc_q  <= pc_inc;
              state <= S_FETCH;
            end
            default: begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end
          endcase
        end
        S_MEM: begin
          // address, direction and store data stay frozen in registers until the ack
          if (dmem_ack) begin
            dmem_we_q <= 1'b0;
            if (dmem_we_q) begin
              pc_q  <= pc_inc;
              state <= S_FETCH;
            end else begin
              res_q <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (rd != '0) regs[rd] <= res_q;
          pc_q  <= pc_inc;
          state <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // gating with reset drops the fetch request at once, since state already reads FETCH in reset
  assign imem_req   = (state == S_FETCH) && PCrst_n;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = sd_q;
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign halted     = halted_q;
  assign dbg_rdata  = rreg(dbg_raddr);

endmodule
